// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers and a start/busy handshake
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic done_q;
  logic fin, acc;
  logic [2*WIDTH-1:0] mul_s, mul_u, res;
  logic sgn, na, nb;
  logic [WIDTH-1:0] ua, ub, uq, ur, sq, sr;
  assign busy = state_q == RUN;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign fin  = state_q == RUN && cnt_q == CW'(1);
  assign acc  = start && (state_q == IDLE || fin) && op != 3'd0 && op != 3'd7;
  // Signed division runs on magnitudes; most-negative / -1 then falls out as lo=rs, hi=0.
  always_comb begin
    mul_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    mul_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    sgn   = op_q == 3'd3;
    na    = sgn && a_q[WIDTH-1];
    nb    = sgn && b_q[WIDTH-1];
    ua    = na ? -a_q : a_q;
    ub    = nb ? -b_q : b_q;
    uq    = ub == '0 ? '0 : ua / ub;
    ur    = ub == '0 ? '0 : ua % ub;
    sq    = na ^ nb ? -uq : uq;
    sr    = na ? -ur : ur;
    res   = op_q == 3'd1 ? mul_s : op_q == 3'd2 ? mul_u : b_q == '0 ? {hi_q, lo_q} : {sr, sq};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= fin;
      if (state_q == RUN) cnt_q <= cnt_q - 1'b1;
      if (fin) begin
        {hi_q, lo_q} <= res;
        state_q      <= IDLE;
      end
      if (acc) begin
        if (op == 3'd5) hi_q <= rs;
        else if (op == 3'd6) lo_q <= rs;
        else begin
          state_q <= RUN;
          cnt_q   <= op <= 3'd2 ? MC : DC;
          op_q    <= op;
          a_q     <= rs;
          b_q     <= rt;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed scoreboard bench for mdu_unit
module tb_mdu_unit;
  logic clk = 0, reset = 0, start = 0;
  logic [2:0] op = 0;
  logic [31:0] rs = 0, rt = 0;
  logic busy, done;
  logic [31:0] hi, lo;
  int ncmp = 0, nfail = 0;
  logic [63:0] sb[$];

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic void check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else check("result_hilo", {hi, lo}, sb.pop_front());
    end
  end

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1; op = o; rs = a; rt = b;
  endtask

  task automatic idle_in();
    start = 0; op = 0; rs = $urandom; rt = $urandom;
  endtask

  task automatic wait_busy(input string tag, input int n);
    int k = 0;
    while (busy && k < 100) begin k++; @(negedge clk); end
    check({tag, "_busy_cycles"}, k, n);
    check({tag, "_done_pulse"}, done, 1'b1);
    check({tag, "_busy_low_at_done"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_single"}, done, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    @(negedge clk); drive(o, a, b);
    @(negedge clk); idle_in();
    wait_busy(tag, n);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    reset = 1;

    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
    run_op("mult_neg", 3'd1, 32'hFFFFFFFE, 32'h3, 5);
    sb.push_back({32'hFFFFFFFE, 32'h00000001});
    run_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("div_neg7_2", 3'd3, 32'hFFFFFFF9, 32'h2, 10);

    @(negedge clk); drive(3'd5, 32'h11, 32'h0);
    @(negedge clk); drive(3'd6, 32'h22, 32'h0);
    check("mthi_visible", hi, 32'h11);
    check("mthi_no_busy", busy, 1'b0);
    @(negedge clk); idle_in();
    check("mtlo_visible", lo, 32'h22);
    check("mtlo_no_done", done, 1'b0);
    sb.push_back({32'h11, 32'h22});
    run_op("divu_by_zero", 3'd4, 32'h1234, 32'h0, 10);
    sb.push_back({32'h0, 32'h80000000});
    run_op("div_overflow", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10);

    sb.push_back({32'h0, 32'd42});
    @(negedge clk); drive(3'd1, 32'd6, 32'd7);
    @(negedge clk); idle_in();
    @(negedge clk); drive(3'd5, 32'hDEAD, 32'h0);
    @(negedge clk); drive(3'd3, 32'h100, 32'h3);
    @(negedge clk); idle_in();
    check("ignored_still_busy", busy, 1'b1);
    k = 3;
    while (busy && k < 100) begin k++; @(negedge clk); end
    check("ignored_busy_cycles", k, 5);
    @(negedge clk);
    check("ignored_no_extra_busy", busy, 1'b0);
    check("ignored_hi", hi, 32'h0);

    sb.push_back({32'h0, 32'd12});
    sb.push_back({32'h0, 32'd25});
    @(negedge clk); drive(3'd1, 32'd3, 32'd4);
    @(negedge clk); idle_in();
    repeat (4) @(negedge clk);
    check("b2b_last_busy", busy, 1'b1);
    drive(3'd1, 32'd5, 32'd5);
    @(negedge clk); idle_in();
    check("b2b_no_bubble", busy, 1'b1);
    check("b2b_first_done", done, 1'b1);
    k = 0;
    while (busy && k < 100) begin k++; @(negedge clk); end
    check("b2b_second_busy", k, 5);
    check("b2b_second_done", done, 1'b1);

    @(negedge clk); drive(3'd3, 32'd100, 32'd7);
    @(negedge clk); idle_in();
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 0;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_hi", hi, 32'h0);
    check("async_lo", lo, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1;
    k = 0;
    repeat (15) begin @(negedge clk); if (done) k++; end
    check("async_no_done", k, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
